gshare_btb: RTL and testbench

Parametrised next-generation branch predictor for the fetch unit: a gshare pattern history table (PHT) of saturating counters indexed by PC XOR global history, plus a tagged branch target buffer (BTB). It serves a combinational lookup at fetch and accepts a resolution packet from the decode/execute stage. That packet trains the tables and repairs the speculative global history on a misprediction. It replaces the fixed-size, single-mode predictor, adding configurable depth, history length, counter width and full-tag aliasing protection.

---
 rtl/gshare_btb.sv | 159 +++++++++++++++
 tb/tb_gshare_btb.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/gshare_btb.sv
// rtl/gshare_btb.sv - gshare direction predictor with tagged branch target buffer
//
// Purpose: fetch-time branch prediction. A PHT of saturating counters indexed
// by PC XOR global history supplies direction; a direct-mapped, fully tagged
// BTB supplies targets. A resolution packet trains both tables and repairs
// the speculative global history on a misprediction.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   f_valid, f_pc, f_op      fetch lookup request
//   p_taken, p_target        predicted redirect and next PC
//   p_hit                    BTB valid and tag match
//   p_ghr                    history snapshot used for this lookup
//   r_valid, r_pc, r_ghr     resolution packet and its fetch-time history
//   r_is_br, r_is_jal        instruction class
//   r_taken, r_target        actual outcome and taken target
//   r_pred_taken/_target     prediction captured at fetch
//   r_mispredict, r_redirect redirect request and correct next PC

`ifndef OPCODE_SIZE
`define OPCODE_SIZE 7
`endif
`ifndef BTYPE_OP
`define BTYPE_OP 7'b1100011
`endif
`ifndef JAL_OP
`define JAL_OP 7'b1101111
`endif

module gshare_btb #(
  parameter int ENTRIES = 512,
  parameter int HIST_W  = 8,
  parameter int CNT_W   = 2,
  parameter int PC_W    = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    f_valid,
  input  logic [PC_W-1:0]         f_pc,
  input  logic [`OPCODE_SIZE-1:0] f_op,
  output logic                    p_taken,
  output logic [PC_W-1:0]         p_target,
  output logic                    p_hit,
  output logic [HIST_W-1:0]       p_ghr,
  input  logic                    r_valid,
  input  logic [PC_W-1:0]         r_pc,
  input  logic [HIST_W-1:0]       r_ghr,
  input  logic                    r_is_br,
  input  logic                    r_is_jal,
  input  logic                    r_taken,
  input  logic [PC_W-1:0]         r_target,
  input  logic                    r_pred_taken,
  input  logic [PC_W-1:0]         r_pred_target,
  output logic                    r_mispredict,
  output logic [PC_W-1:0]         r_redirect
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W - 2;
  // Weakly-not-taken: the value just below the taken threshold.
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((1 << (CNT_W - 1)) - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic                 btb_valid  [ENTRIES];
  logic [TAG_W-1:0]     btb_tag    [ENTRIES];
  logic [PC_W-1:0]      btb_target [ENTRIES];
  logic [CNT_W-1:0]     pht        [ENTRIES];
  logic [HIST_W-1:0]    ghr;
  logic [HIST_W-1:0]    ghr_next;

  // Instruction bits [1:0] never take part in indexing or tagging.
  logic unused;
  assign unused = &{1'b0, f_pc[1:0], r_pc[1:0]};

  // Shifting left then OR-ing keeps the expression legal for HIST_W = 1.
  function automatic logic [HIST_W-1:0] shift_in(input logic [HIST_W-1:0] h,
                                                  input logic b);
    return (h << 1) | HIST_W'(b);
  endfunction

  // Lookup path
  logic [IDX_W-1:0] f_bidx;
  logic [IDX_W-1:0] f_pidx;
  logic [TAG_W-1:0] f_tag;
  logic             f_is_br;
  logic             f_is_jal;

  assign f_bidx   = f_pc[IDX_W+1:2];
  assign f_pidx   = f_bidx ^ IDX_W'(ghr);
  assign f_tag    = f_pc[PC_W-1:IDX_W+2];
  assign f_is_br  = (f_op == `BTYPE_OP);
  assign f_is_jal = (f_op == `JAL_OP);

  assign p_hit    = btb_valid[f_bidx] && (btb_tag[f_bidx] == f_tag);
  assign p_taken  = p_hit && ((f_is_br && pht[f_pidx][CNT_W-1]) || f_is_jal);
  assign p_target = p_taken ? btb_target[f_bidx] : f_pc + PC_W'(4);
  assign p_ghr    = ghr;

  // Resolution path
  logic [IDX_W-1:0] r_bidx;
  logic [IDX_W-1:0] r_pidx;
  logic [TAG_W-1:0] r_tag;

  assign r_bidx = r_pc[IDX_W+1:2];
  assign r_pidx = r_bidx ^ IDX_W'(r_ghr);
  assign r_tag  = r_pc[PC_W-1:IDX_W+2];

  assign r_mispredict = r_valid && (r_is_br || r_is_jal) &&
                        ((r_taken != r_pred_taken) ||
                         (r_taken && (r_target != r_pred_target)));
  assign r_redirect   = r_taken ? r_target : r_pc + PC_W'(4);

  // A repair wins over the same-cycle speculative shift: that fetch is
  // on the wrong path and is being squashed.
  always_comb begin
    ghr_next = ghr;
    if (r_mispredict && r_is_br)
      ghr_next = shift_in(r_ghr, r_taken);
    else if (r_mispredict && r_is_jal)
      ghr_next = r_ghr;
    else if (f_valid && f_is_br)
      ghr_next = shift_in(ghr, p_taken);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ghr <= '0;
    else
      ghr <= ghr_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb_valid[i]  <= 1'b0;
        btb_tag[i]    <= '0;
        btb_target[i] <= '0;
        pht[i]        <= CNT_INIT;
      end
    end else if (r_valid) begin
      if (r_is_br) begin
        if (r_taken) begin
          if (pht[r_pidx] != CNT_MAX)
            pht[r_pidx] <= pht[r_pidx] + CNT_W'(1);
        end else begin
          if (pht[r_pidx] != '0)
            pht[r_pidx] <= pht[r_pidx] - CNT_W'(1);
        end
      end
      // Direct-mapped overwrite; not-taken outcomes leave the BTB alone.
      if ((r_is_br || r_is_jal) && r_taken) begin
        btb_valid[r_bidx]  <= 1'b1;
        btb_tag[r_bidx]    <= r_tag;
        btb_target[r_bidx] <= r_target;
      end
    end
  end

endmodule

// File: tb/tb_gshare_btb.sv
// tb/tb_gshare_btb.sv - directed testbench for gshare_btb

`ifndef OPCODE_SIZE
`define OPCODE_SIZE 7
`endif
`ifndef BTYPE_OP
`define BTYPE_OP 7'b1100011
`endif
`ifndef JAL_OP
`define JAL_OP 7'b1101111
`endif

module tb_gshare_btb;

  localparam logic [6:0] BR  = `BTYPE_OP;
  localparam logic [6:0] JAL = `JAL_OP;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  logic        f_valid, p_taken, p_hit, r_valid, r_is_br, r_is_jal, r_taken;
  logic        r_pred_taken, r_mispredict;
  logic [31:0] f_pc, p_target, r_pc, r_target, r_pred_target, r_redirect;
  logic [6:0]  f_op;
  logic [3:0]  p_ghr, r_ghr;

  gshare_btb #(.ENTRIES(16), .HIST_W(4), .CNT_W(2), .PC_W(32)) dut (
    .clk(clk), .rst(rst),
    .f_valid(f_valid), .f_pc(f_pc), .f_op(f_op),
    .p_taken(p_taken), .p_target(p_target), .p_hit(p_hit), .p_ghr(p_ghr),
    .r_valid(r_valid), .r_pc(r_pc), .r_ghr(r_ghr),
    .r_is_br(r_is_br), .r_is_jal(r_is_jal), .r_taken(r_taken),
    .r_target(r_target), .r_pred_taken(r_pred_taken),
    .r_pred_target(r_pred_target),
    .r_mispredict(r_mispredict), .r_redirect(r_redirect)
  );

  logic        b_f_valid, b_p_taken, b_p_hit, b_r_valid, b_r_is_br, b_r_is_jal;
  logic        b_r_taken, b_r_pred_taken, b_r_mispredict;
  logic [31:0] b_f_pc, b_p_target, b_r_pc, b_r_target, b_r_pred_target, b_r_redirect;
  logic [6:0]  b_f_op;
  logic [0:0]  b_p_ghr, b_r_ghr;

  gshare_btb #(.ENTRIES(16), .HIST_W(1), .CNT_W(1), .PC_W(32)) dut1 (
    .clk(clk), .rst(rst),
    .f_valid(b_f_valid), .f_pc(b_f_pc), .f_op(b_f_op),
    .p_taken(b_p_taken), .p_target(b_p_target), .p_hit(b_p_hit), .p_ghr(b_p_ghr),
    .r_valid(b_r_valid), .r_pc(b_r_pc), .r_ghr(b_r_ghr),
    .r_is_br(b_r_is_br), .r_is_jal(b_r_is_jal), .r_taken(b_r_taken),
    .r_target(b_r_target), .r_pred_taken(b_r_pred_taken),
    .r_pred_target(b_r_pred_target),
    .r_mispredict(b_r_mispredict), .r_redirect(b_r_redirect)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic res_a(input logic v, input logic br, input logic jal,
                       input logic [31:0] pc, input logic [3:0] gh,
                       input logic tk, input logic [31:0] tgt,
                       input logic ptk, input logic [31:0] ptgt);
    r_valid = v; r_is_br = br; r_is_jal = jal; r_pc = pc; r_ghr = gh;
    r_taken = tk; r_target = tgt; r_pred_taken = ptk; r_pred_target = ptgt;
  endtask

  task automatic res_b(input logic v, input logic [31:0] pc, input logic gh,
                       input logic tk, input logic [31:0] tgt,
                       input logic ptk, input logic [31:0] ptgt);
    b_r_valid = v; b_r_is_br = 1'b1; b_r_is_jal = 1'b0; b_r_pc = pc;
    b_r_ghr = gh; b_r_taken = tk; b_r_target = tgt;
    b_r_pred_taken = ptk; b_r_pred_target = ptgt;
  endtask

  initial begin
    #100000;
    $error("FAIL timeout: simulation did not finish");
    $finish;
  end

  initial begin
    f_valid = 0; f_pc = 0; f_op = 0;
    res_a(0, 0, 0, 0, 0, 0, 0, 0, 0);
    b_f_valid = 0; b_f_pc = 0; b_f_op = 0;
    res_b(0, 0, 0, 0, 0, 0, 0);
    b_r_is_br = 0;

    tick(); tick();
    rst = 0;
    #1;
    chk("init_ghr", p_ghr, 4'b0000);
    chk("init_pht5", dut.pht[5], 2'b01);

    f_pc = 32'h40; f_op = BR; #1;
    chk("cold_hit", p_hit, 1'b0);
    chk("cold_taken", p_taken, 1'b0);
    chk("cold_target", p_target, 32'h44);
    res_a(1, 1, 0, 32'h40, 4'b0000, 1, 32'h80, 0, 32'h44); #1;
    chk("cold_mispredict", r_mispredict, 1'b1);
    chk("cold_redirect", r_redirect, 32'h80);
    tick();
    r_valid = 0; #1;
    chk("cold_ghr", p_ghr, 4'b0001);
    chk("cold_pht0", dut.pht[0], 2'b10);
    f_op = JAL; #1;
    chk("cold_btb_hit", p_hit, 1'b1);
    chk("cold_btb_target", p_target, 32'h80);

    res_a(1, 1, 0, 32'h40, 4'b0000, 1, 32'h80, 1, 32'h80); #1;
    chk("train_no_mispredict", r_mispredict, 1'b0);
    tick(); tick();
    r_valid = 0; #1;
    chk("train_pht0_sat", dut.pht[0], 2'b11);
    chk("train_ghr_hold", p_ghr, 4'b0001);

    res_a(1, 0, 1, 32'h204, 4'b0000, 1, 32'h300, 0, 32'h208); #1;
    chk("jal_mispredict", r_mispredict, 1'b1);
    tick();
    r_valid = 0; #1;
    chk("jal_repair_ghr", p_ghr, 4'b0000);

    f_valid = 1; f_pc = 32'h40; f_op = BR; #1;
    chk("trained_taken", p_taken, 1'b1);
    chk("trained_target", p_target, 32'h80);
    tick();
    f_valid = 0; #1;
    chk("spec_shift_1", p_ghr, 4'b0001);

    f_pc = 32'h440; f_op = JAL; #1;
    chk("alias_hit", p_hit, 1'b0);
    chk("alias_taken", p_taken, 1'b0);
    chk("alias_target", p_target, 32'h444);
    f_valid = 1; f_op = BR;
    tick();
    f_valid = 0; #1;
    chk("spec_shift_0", p_ghr, 4'b0010);

    res_a(1, 0, 1, 32'h208, 4'b1011, 1, 32'h300, 0, 32'h20c);
    tick();
    r_valid = 0; #1;
    chk("ghr_1011", p_ghr, 4'b1011);

    f_valid = 1; f_pc = 32'h40; f_op = BR;
    res_a(1, 1, 0, 32'h48, 4'b0010, 0, 32'h0, 1, 32'h99); #1;
    chk("simul_mispredict", r_mispredict, 1'b1);
    chk("simul_redirect", r_redirect, 32'h4c);
    tick();
    f_valid = 0; r_valid = 0; #1;
    chk("simul_ghr", p_ghr, 4'b0100);
    chk("simul_pht0_dec", dut.pht[0], 2'b10);

    res_a(0, 1, 0, 32'h40, 4'b0000, 1, 32'h80, 0, 32'h44); #1;
    chk("stale_mispredict", r_mispredict, 1'b0);
    tick();
    chk("stale_pht0", dut.pht[0], 2'b10);
    chk("stale_ghr", p_ghr, 4'b0100);

    f_pc = 32'h100; f_op = 0;
    #2 rst = 1;
    #1;
    chk("rst_hit", p_hit, 1'b0);
    chk("rst_taken", p_taken, 1'b0);
    chk("rst_ghr", p_ghr, 4'b0000);
    chk("rst_target", p_target, 32'h104);
    chk("rst_pht0", dut.pht[0], 2'b01);
    f_pc = 32'h40; f_op = JAL; #1;
    chk("rst_btb_cleared", p_hit, 1'b0);
    @(negedge clk);
    rst = 0; #1;
    chk("post_rst_target", p_target, 32'h44);

    chk("b_pht_reset", dut1.pht[0], 1'b0);
    chk("b_ghr_reset", b_p_ghr, 1'b0);
    res_b(1, 32'h40, 1'b0, 1, 32'h80, 0, 32'h44); #1;
    chk("b_mispredict_taken", b_r_mispredict, 1'b1);
    tick();
    b_r_valid = 0; #1;
    chk("b_ghr_taken", b_p_ghr, 1'b1);
    chk("b_pht0_set", dut1.pht[0], 1'b1);
    res_b(1, 32'h40, 1'b1, 0, 32'h0, 1, 32'h80);
    tick();
    b_r_valid = 0; #1;
    chk("b_ghr_nt", b_p_ghr, 1'b0);
    b_f_pc = 32'h40; b_f_op = BR; #1;
    chk("b_taken", b_p_taken, 1'b1);
    chk("b_target_taken", b_p_target, 32'h80);
    res_b(1, 32'h40, 1'b0, 0, 32'h0, 1, 32'h80);
    tick();
    b_r_valid = 0; #1;
    chk("b_not_taken", b_p_taken, 1'b0);
    chk("b_target_nt", b_p_target, 32'h44);
    chk("b_ghr_final", b_p_ghr, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
